// File: rtl/key_event_pkg.sv
// key_event_pkg
//   Shared definitions for the key event detector: the FSM state encoding
//   and the default width of the hold counter.
package key_event_pkg;

  localparam int CNT_W_DEFAULT = 26;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    HELD     = 2'd2,
    REPEAT   = 2'd3
  } state_t;

endpackage

// File: rtl/key_event.sv
// key_event
//   Turns a debounced, clk-synchronous active-low key level into one-cycle
//   event strobes: press, release, long-press, and auto-repeat.
//   All outputs are registered, so every strobe appears in the cycle after
//   the clock edge that sampled the key level that caused it.
//
// Parameters
//   LONG_CYCLES   hold time in clk cycles before long_pulse
//   REPEAT_CYCLES auto-repeat period in clk cycles after long_pulse
//   CNT_W         hold-counter width
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-low
//   key_n         debounced key level, 0 = pressed
//   press_pulse   one-cycle strobe on press
//   release_pulse one-cycle strobe on release
//   long_pulse    one-cycle strobe when the hold reaches LONG_CYCLES
//   repeat_pulse  one-cycle strobe every REPEAT_CYCLES after long_pulse
//   held          high while the key is recognised as pressed
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  // Both periods must fit in the counter and be at least two cycles long.
  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_long
    $error("key_event: LONG_CYCLES out of range for CNT_W");
  end
  if (REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_repeat
    $error("key_event: REPEAT_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, release_nxt, long_nxt, repeat_nxt, held_nxt;

  // State, counter and all outputs are registered together. Starting in
  // WAIT_REL means a key already down at reset release is ignored until it
  // has been seen released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= WAIT_REL;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      held          <= held_nxt;
    end
  end

  // Next-state and next-output logic. Release is tested before the terminal
  // count, so a release landing on the terminal cycle suppresses the
  // long/repeat strobe. The counter is cleared at every terminal count, so it
  // never climbs past the larger of the two periods.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;

    case (state)
      WAIT_REL: begin
        if (key_n) state_nxt = IDLE;
      end
      IDLE: begin
        if (!key_n) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end
      end
      HELD: begin
        if (key_n) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = REPEAT;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (key_n) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (cnt == REPEAT_LAST) begin
          cnt_nxt    = '0;
          repeat_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = WAIT_REL;
        cnt_nxt   = '0;
      end
    endcase

    held_nxt = (state_nxt == HELD) || (state_nxt == REPEAT);
  end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, hold time in clk cycles (1 s at 50 MHz) before long-press is declared.
REQ-002 Parameter REPEAT_CYCLES, default 10_000_000, auto-repeat period in clk cycles (200 ms at 50 MHz) after long-press.
REQ-003 Parameter CNT_W, default 26, hold-counter width.
REQ-004 clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 key_n  input  1  debounced key level, active-low (1 = released), already synchronous to clk.
REQ-007 press_pulse  output  1  one-cycle strobe on press.
REQ-008 release_pulse  output  1  one-cycle strobe on release.
REQ-009 long_pulse  output  1  one-cycle strobe when hold reaches LONG_CYCLES.
REQ-010 repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES after long_pulse while still held.
REQ-011 held  output  1  high while the key is recognised as pressed (state HELD or REPEAT).

Function
REQ-012 The FSM SHALL have four states: WAIT_REL, IDLE, HELD, REPEAT.
REQ-013 WAIT_REL: key_n=1 -> IDLE; key_n=0 -> stay; no pulses.
REQ-014 IDLE: key_n=0 -> HELD, cnt<=0, press_pulse=1 next cycle; key_n=1 -> stay.
REQ-015 HELD: key_n=1 -> IDLE with release_pulse; else if cnt==LONG_CYCLES-1 -> REPEAT, cnt<=0, long_pulse; else cnt<=cnt+1.
REQ-016 REPEAT: key_n=1 -> IDLE with release_pulse; else if cnt==REPEAT_CYCLES-1 -> stay, cnt<=0, repeat_pulse; else cnt<=cnt+1.
REQ-017 All outputs SHALL be registered; each pulse is high exactly in the cycle after the clock edge that sampled the triggering key_n value (latency 1).
REQ-018 held SHALL be 1 in the same cycle as press_pulse and 0 in the same cycle as release_pulse.
REQ-019 long_pulse SHALL occur exactly LONG_CYCLES cycles after press_pulse; first repeat_pulse exactly REPEAT_CYCLES cycles after long_pulse.
REQ-020 Release sampled in the same cycle as a terminal count: release wins, no long_pulse/repeat_pulse issued.
REQ-021 At most one of the four pulses SHALL be high in any cycle.
REQ-022 A press shorter than LONG_CYCLES SHALL produce exactly one press_pulse and one release_pulse, no long/repeat pulse.
REQ-023 cnt SHALL never exceed max(LONG_CYCLES,REPEAT_CYCLES)-1; no wrap-around while held indefinitely.
REQ-024 LONG_CYCLES and REPEAT_CYCLES SHALL each be >=2 and < 2**CNT_W; violation is an elaboration error.

Reset
REQ-025 On rst=0: state=WAIT_REL, cnt=0, all pulses=0, held=0, immediately and independent of clk.
REQ-026 A key held through reset release SHALL produce no pulse until key_n is seen at 1, then pressed again.
REQ-027 Reset asserted mid-hold SHALL not emit release_pulse.

Structure
REQ-028 Package key_event_pkg SHALL hold the state enumeration and CNT_W default.
REQ-029 No sub-module; top level instantiates one key_event per debounce output, key_n tied to that instance's key_out.

Verification (bench overrides LONG_CYCLES=10, REPEAT_CYCLES=4)
REQ-030 rst low then high with key_n=1; key_n=0 for 3 cycles -> press_pulse 1 cycle, held 3 cycles, release_pulse 1 cycle, no long_pulse.
REQ-031 key_n=0 for 25 cycles -> press_pulse at t+1, long_pulse at t+11, repeat_pulse at t+15, t+19, t+23, release_pulse after key_n=1.
REQ-032 key_n=1 sampled exactly in the cycle cnt==9 in HELD -> release_pulse only, no long_pulse.
REQ-033 key_n=0 during and after reset release for 20 cycles -> no pulses, held=0; key_n=1 then 0 -> press_pulse.
REQ-034 rst asserted at cycle 12 of a hold -> all outputs 0 asynchronously, no release_pulse; state WAIT_REL.
REQ-035 Random key_n stream, 10k cycles -> pulse counts: press==release (±1 if held at end), never two pulses in one cycle.
